// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit: 32-step shift-add multiply or restoring divide into HI/LO.
// Define MDU_DIV_EN to build the divider; without it DIV/DIVU take the divide-by-zero path.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CNT_W = 6;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
  state_t state_q, state_d;

  logic [CNT_W-1:0]   cnt_q;
  logic               div_q, neg_lo_q, neg_hi_q;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q;

  logic               issue, signed_op, s1_neg, s2_neg, div_zero;
  logic [WIDTH-1:0]   src1_mag, src2_mag;
  logic [WIDTH:0]     mul_sum;

  function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v,
                                                 input logic is_signed);
    logic signed [WIDTH-1:0] n;
    n = -v;
    return (is_signed && v[WIDTH-1]) ? $unsigned(n) : $unsigned(v);
  endfunction

  function automatic logic [WIDTH-1:0] fix_sign(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? (~v + WIDTH'(1)) : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] fix_sign_wide(input logic [2*WIDTH-1:0] v,
                                                       input logic neg);
    return neg ? (~v + (2*WIDTH)'(1)) : v;
  endfunction

  always_comb begin
    issue     = (state_q == IDLE) && start;
    signed_op = ~op[0];
    s1_neg    = signed_op & src1[WIDTH-1];
    s2_neg    = signed_op & src2[WIDTH-1];
    src1_mag  = magnitude(src1, signed_op);
    src2_mag  = magnitude(src2, signed_op);
`ifdef MDU_DIV_EN
    div_zero  = op[1] && (src2 == '0);
`else
    div_zero  = op[1];
`endif
  end

  // Iteration step: right-shifting shift-add multiply, or left-shifting restoring divide
  always_comb begin
    mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    acc_d   = {mul_sum, acc_q[WIDTH-1:1]};
`ifdef MDU_DIV_EN
    if (div_q) begin
      if (acc_q[2*WIDTH-1:WIDTH-1] >= {1'b0, opnd_q})
        acc_d = {acc_q[2*WIDTH-2:WIDTH-1] - opnd_q, acc_q[WIDTH-2:0], 1'b1};
      else
        acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    busy    = (state_q != IDLE);
    case (state_q)
      IDLE:    if (start) state_d = div_zero ? FIX : CALC;
      CALC:    if (cnt_q == LAST_STEP) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      div_q    <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      state_q <= state_d;
      done    <= (state_q == FIX);
      if (issue) begin
        cnt_q    <= '0;
        div_q    <= op[1];
        neg_lo_q <= ~div_zero & (s1_neg ^ s2_neg);
        neg_hi_q <= div_zero ? 1'b0 : (op[1] ? s1_neg : (s1_neg ^ s2_neg));
      end else if (state_q == CALC) begin
        cnt_q <= (cnt_q == LAST_STEP) ? '0 : cnt_q + CNT_W'(1);
      end
      // Multiply negates the full 64-bit product; divide fixes quotient and remainder separately
      if (state_q == FIX) begin
        if (div_q) begin
          hi <= fix_sign(acc_q[2*WIDTH-1:WIDTH], neg_hi_q);
          lo <= fix_sign(acc_q[WIDTH-1:0], neg_lo_q);
        end else begin
          {hi, lo} <= fix_sign_wide(acc_q, neg_lo_q);
        end
      end
    end
  end

  // Divide-by-zero preloads the final answer so FIX passes it straight through
  always_ff @(posedge clk_i) begin
    if (issue) begin
      if (div_zero) begin
        acc_q  <= {src1, {WIDTH{1'b1}}};
        opnd_q <= src2;
      end else if (op[1]) begin
        acc_q  <= {{WIDTH{1'b0}}, src1_mag};
        opnd_q <= src2_mag;
      end else begin
        acc_q  <= {{WIDTH{1'b0}}, src2_mag};
        opnd_q <= src1_mag;
      end
    end else if (state_q == CALC) begin
      acc_q <= acc_d;
    end
  end
endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed cases plus random ops against an arithmetic model.
module tb_mul_div_unit;
  logic        clk_i = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src1, src2;
  logic        busy, done;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  mul_div_unit #(.WIDTH(32)) dut (
    .clk_i(clk_i), .rst_n(rst_n), .start(start), .op(op),
    .src1(src1), .src2(src2), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model(input logic [1:0] m_op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] eh, output logic [31:0] el, output int lat);
    longint      sp;
    logic [63:0] up;
    int          sa, sb;
    sa  = a;
    sb  = b;
    lat = 33;
    case (m_op)
      2'b00: begin sp = longint'(sa) * longint'(sb); {eh, el} = sp; end
      2'b01: begin up = {32'd0, a} * {32'd0, b}; {eh, el} = up; end
      default: begin
`ifdef MDU_DIV_EN
        if (b == 32'd0) begin
          el = 32'hFFFF_FFFF; eh = a; lat = 1;
        end else if (m_op == 2'b11) begin
          el = a / b; eh = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          el = 32'h8000_0000; eh = 32'd0;
        end else begin
          el = sa / sb; eh = sa % sb;
        end
`else
        el = 32'hFFFF_FFFF; eh = a; lat = 1;
`endif
      end
    endcase
  endfunction

  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                        input int lat, input bit noise);
    int cyc;
    bit seen;
    op = o; src1 = a; src2 = b; start = 1'b1;
    @(posedge clk_i); #1;
    start = 1'b0; op = 2'($urandom); src1 = $urandom; src2 = $urandom;
    check({tag, "_busy"}, busy, 1);
    check({tag, "_done_clr"}, done, 0);
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 40) begin
      if (noise && (cyc == 4 || cyc == 11)) begin
        start = 1'b1; op = 2'($urandom); src1 = $urandom; src2 = $urandom;
      end
      @(posedge clk_i); #1;
      start = 1'b0;
      cyc++;
      if (done) seen = 1'b1;
    end
    check({tag, "_done_seen"}, seen, 1);
    check({tag, "_latency"}, cyc, lat);
    check({tag, "_hi"}, hi, eh);
    check({tag, "_lo"}, lo, el);
    check({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [1:0]  r_op;
    logic [31:0] r_a, r_b, r_hi, r_lo;
    int          r_lat, dcount;

    rst_n = 1'b0; start = 1'b0; op = 2'b00; src1 = '0; src2 = '0;
    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    @(negedge clk_i); rst_n = 1'b1;
    @(posedge clk_i); #1;

    run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 33, 1'b0);
    run_op("mult_neg", 2'b00, 32'hFFFF_FFF9, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 33, 1'b1);
`ifdef MDU_DIV_EN
    run_op("div_neg", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33, 1'b0);
    run_op("divu", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 33, 1'b0);
`else
    run_op("div_neg", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1, 1'b0);
    run_op("divu", 2'b11, 32'd100, 32'd7, 32'd100, 32'hFFFF_FFFF, 1, 1'b0);
`endif
    run_op("divu_zero", 2'b11, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1, 1'b0);
    repeat (5) @(posedge clk_i);
    #1;
    check("hold_hi", hi, 32'd5);
    check("hold_lo", lo, 32'hFFFF_FFFF);
`ifdef MDU_DIV_EN
    run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 33, 1'b0);
`else
    run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 1, 1'b0);
`endif

    for (int i = 0; i < 24; i++) begin
      r_op = 2'($urandom);
      r_a  = (i % 4 == 1) ? 32'($urandom_range(0, 200)) - 32'd100 : 32'($urandom);
      r_b  = (i % 6 == 5) ? 32'd0 :
             ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 9)) : 32'($urandom);
      if (i % 8 == 3) r_b = -r_b;
      model(r_op, r_a, r_b, r_hi, r_lo, r_lat);
      run_op($sformatf("rand%0d_op%0d", i, r_op), r_op, r_a, r_b, r_hi, r_lo, r_lat, i[0]);
    end

    run_op("multu_small", 2'b01, 32'd3, 32'd5, 32'd0, 32'd15, 33, 1'b0);
    op = 2'b00; src1 = 32'd123; src2 = 32'd456; start = 1'b1;
    @(posedge clk_i); #1;
    start = 1'b0;
    repeat (10) @(posedge clk_i);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_hi", hi, 0);
    check("abort_lo", lo, 0);
    @(negedge clk_i); rst_n = 1'b1;
    dcount = 0;
    repeat (40) begin
      @(posedge clk_i); #1;
      if (done) dcount++;
    end
    check("abort_no_done", dcount, 0);
    run_op("post_reset", 2'b01, 32'd6, 32'd7, 32'd0, 32'd42, 33, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Iterative multi-cycle multiply/divide unit for the CPU's execute stage, working alongside the combinational `alu`. Decode issues MULT/MULTU/DIV/DIVU via a one-cycle `start` pulse. The unit runs a 32-step shift-add or restoring-divide loop and returns a 64-bit result in HI/LO registers with a one-cycle `done` pulse. The control path stalls on `busy`.

## Interface
- `WIDTH`, 32, operand width; the iteration count equals `WIDTH`.
- `clk_i`  input  1  clock; all state updates on the rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `start`  input  1  issue strobe; sampled only while idle.
- `op`  input  2  operation: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
- `src1`  input  WIDTH  multiplicand / dividend.
- `src2`  input  WIDTH  multiplier / divisor.
- `busy`  output  1  operation in flight.
- `done`  output  1  one-cycle completion pulse.
- `hi`  output  WIDTH  product[63:32] / remainder.
- `lo`  output  WIDTH  product[31:0] / quotient.

## Operation
- States:
  - IDLE: waits for `start`.
  - CALC: iterates; a 6-bit counter runs 0..31.
  - FIX: applies sign correction and loads HI/LO.
- IDLE -> CALC on `start`=1:
  - latch `op`.
  - latch |src1| and |src2| for signed ops (two's-complement magnitude) or the raw values for unsigned ops.
  - latch the result sign: MULT s1^s2; DIV quotient s1^s2, remainder s1.
- CALC, multiply: a 64-bit accumulator; each step adds the multiplicand to the upper half if acc[0] is set, then shifts right one position.
- CALC, divide: restoring division; shift {rem,quot} left, subtract the divisor, and keep the result if it is non-negative, setting the quotient bit.
- CALC -> FIX when the counter reaches 31.
- FIX:
  - negate the relevant results per the latched signs.
  - load `hi`/`lo`, assert `done` and return to IDLE.
- Divide by zero is detected at issue and skips CALC; the next cycle is FIX with `lo`=32'hFFFFFFFF and `hi`=src1.
- Signed DIV of 32'h80000000 by 32'hFFFFFFFF gives `lo`=32'h80000000, `hi`=0. No trap is raised.
- `start` while `busy` is ignored, and the in-flight operation is unaffected.
- `hi`/`lo` hold their values between completions.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `hi`=0, `lo`=0, counter 0.
- Start at edge N; `busy`=1 from after edge N.
- CALC steps occur at edges N+1..N+32; the FIX load happens at edge N+33.
- After edge N+33: `done`=1 for one cycle, `busy`=0, and `hi`/`lo` are valid.
- Latency is 33 cycles from the start edge to the result.
- Divide by zero: the result is loaded at edge N+1, so latency is 1 cycle.
- A `start` in the cycle where `done`=1 is accepted, so back-to-back issue is possible.
- Asserting `rst_n` mid-operation aborts immediately: all outputs return to their reset values, and no `done` pulse occurs.
- `src1`/`src2`/`op` need only be stable at the start edge.

## Configuration
- `MDU_DIV_EN` defined: DIV and DIVU are implemented as above.
- `MDU_DIV_EN` undefined: the divide datapath is omitted.
  - `op` 10/11 are accepted but take the divide-by-zero path: 1-cycle latency, `lo`=32'hFFFFFFFF, `hi`=src1.
  - Multiply behaviour is unchanged.

## Test plan
- Reset during CALC (after 10 cycles) -> `busy`=0, `hi`=`lo`=0, and no `done` pulse follows.
- MULTU 32'hFFFFFFFF x 32'hFFFFFFFF -> `done` 33 cycles after start, `hi`=32'hFFFFFFFE, `lo`=32'h00000001.
- MULT -7 x 3 -> `hi`=32'hFFFFFFFF, `lo`=32'hFFFFFFEB; also confirm that `start` pulses while busy are ignored.
- DIV -7 / 2 -> `lo`=32'hFFFFFFFD, `hi`=32'hFFFFFFFF; DIVU 100 / 7 -> `lo`=14, `hi`=2.
- DIVU 5 / 0 -> `done` 1 cycle after start, `lo`=32'hFFFFFFFF, `hi`=5; then DIV 32'h80000000 / -1 -> `lo`=32'h80000000, `hi`=0.
